// File: rtl/mem_port_arbiter_if.sv
// Bundle of the imem, dmem and unified memory-port signals seen by the arbiter.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface mem_port_arbiter_if;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;

   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;

   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   modport slave (
      input  imem_addr, imem_rmask,
      output imem_rdata, imem_resp,
      input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      output dmem_rdata, dmem_resp,
      output mem_addr, mem_rmask, mem_wmask, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport master (
      output imem_addr, imem_rmask,
      input  imem_rdata, imem_resp,
      output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      input  dmem_rdata, dmem_resp,
      input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and MEM-stage (dmem) requesters,
// with one pending slot per side and a single outstanding downstream transaction.
module mem_port_arbiter #(
   parameter bit DMEM_PRIO = 1'b1
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   logic [1:0]  state;

   logic        i_pend_v;
   logic [31:0] i_pend_addr;
   logic [3:0]  i_pend_rmask;
   logic        d_pend_v;
   logic [31:0] d_pend_addr;
   logic [31:0] d_pend_wdata;
   logic [3:0]  d_pend_rmask;
   logic [3:0]  d_pend_wmask;

   logic [31:0] mem_addr_q, mem_wdata_q, imem_rdata_q, dmem_rdata_q;
   logic [3:0]  mem_rmask_q, mem_wmask_q;
   logic        imem_resp_q, dmem_resp_q;

   logic        i_new, d_new, i_cand, d_cand, issue_ok, pick_i, pick_d;
   logic [31:0] i_addr_sel, d_addr_sel, d_wdata_sel;
   logic [3:0]  i_rmask_sel, d_rmask_sel, d_wmask_sel;

   // A side with a request pending or in flight ignores further requests until its resp.
   assign i_new = (bus.imem_rmask != 4'h0) && !i_pend_v && (state != BUSY_I);
   assign d_new = ((bus.dmem_rmask | bus.dmem_wmask) != 4'h0) && !d_pend_v && (state != BUSY_D);

   assign i_cand   = (i_pend_v || i_new) && (state != BUSY_I);
   assign d_cand   = (d_pend_v || d_new) && (state != BUSY_D);
   assign issue_ok = (state == IDLE) || bus.mem_resp;
   assign pick_d   = issue_ok && d_cand && (DMEM_PRIO || !i_cand);
   assign pick_i   = issue_ok && i_cand && !pick_d;

   assign i_addr_sel  = i_pend_v ? i_pend_addr  : bus.imem_addr;
   assign i_rmask_sel = i_pend_v ? i_pend_rmask : bus.imem_rmask;
   assign d_addr_sel  = d_pend_v ? d_pend_addr  : bus.dmem_addr;
   assign d_wdata_sel = d_pend_v ? d_pend_wdata : bus.dmem_wdata;
   assign d_rmask_sel = d_pend_v ? d_pend_rmask : bus.dmem_rmask;
   assign d_wmask_sel = d_pend_v ? d_pend_wmask : bus.dmem_wmask;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         i_pend_v     <= 1'b0;
         d_pend_v     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_rmask_q  <= 4'h0;
         mem_wmask_q  <= 4'h0;
         imem_rdata_q <= 32'h0;
         dmem_rdata_q <= 32'h0;
         imem_resp_q  <= 1'b0;
         dmem_resp_q  <= 1'b0;
      end else begin
         mem_rmask_q <= 4'h0;
         mem_wmask_q <= 4'h0;
         imem_resp_q <= 1'b0;
         dmem_resp_q <= 1'b0;

         if (bus.mem_resp && (state == BUSY_I)) begin
            imem_resp_q  <= 1'b1;
            imem_rdata_q <= bus.mem_rdata;
         end
         if (bus.mem_resp && (state == BUSY_D)) begin
            dmem_resp_q  <= 1'b1;
            dmem_rdata_q <= bus.mem_rdata;
         end

         if (pick_i) begin
            mem_addr_q  <= i_addr_sel;
            mem_rmask_q <= i_rmask_sel;
            state       <= BUSY_I;
            i_pend_v    <= 1'b0;
         end else if (pick_d) begin
            mem_addr_q  <= d_addr_sel;
            mem_wdata_q <= d_wdata_sel;
            // A write mask makes it a write even when a read mask rides along.
            if (d_wmask_sel != 4'h0) mem_wmask_q <= d_wmask_sel;
            else                     mem_rmask_q <= d_rmask_sel;
            state       <= BUSY_D;
            d_pend_v    <= 1'b0;
         end else if ((state != IDLE) && bus.mem_resp) begin
            state <= IDLE;
         end

         if (i_new && !pick_i) i_pend_v <= 1'b1;
         if (d_new && !pick_d) d_pend_v <= 1'b1;
      end
   end

   // Slot payloads need no reset; they are qualified by the valid bits above.
   always_ff @(posedge clk) begin
      if (i_new && !pick_i) begin
         i_pend_addr  <= bus.imem_addr;
         i_pend_rmask <= bus.imem_rmask;
      end
      if (d_new && !pick_d) begin
         d_pend_addr  <= bus.dmem_addr;
         d_pend_wdata <= bus.dmem_wdata;
         d_pend_rmask <= bus.dmem_rmask;
         d_pend_wmask <= bus.dmem_wmask;
      end
   end

   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_rmask  = mem_rmask_q;
   assign bus.mem_wmask  = mem_wmask_q;
   assign bus.imem_rdata = imem_rdata_q;
   assign bus.imem_resp  = imem_resp_q;
   assign bus.dmem_rdata = dmem_rdata_q;
   assign bus.dmem_resp  = dmem_resp_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared memory/cache port between the fetch stage (imem, read-only) and the MEM stage (dmem, read/write with byte masks). It captures single-cycle request pulses from each side, issues at most one outstanding transaction downstream, and routes the downstream response and read data back to the owning requester. It sits between the pipeline's imem/dmem ports and the single unified memory port.

## Interface
Parameters:
- DMEM_PRIO, 1, 1: dmem wins simultaneous requests; 0: imem wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  in  32  fetch address, word-aligned, sampled when imem_rmask != 0.
- imem_rmask  in  4  nonzero for one cycle = read request.
- imem_rdata  out  32  read data, valid when imem_resp = 1.
- imem_resp  out  1  one-cycle completion pulse.
- dmem_addr  in  32  data address, [1:0] = 0, sampled when a mask is nonzero.
- dmem_rmask  in  4  nonzero for one cycle = read request.
- dmem_wmask  in  4  nonzero for one cycle = write request.
- dmem_wdata  in  32  write data, lane-aligned to wmask.
- dmem_rdata  out  32  read data, valid when dmem_resp = 1.
- dmem_resp  out  1  one-cycle completion pulse (reads and writes).
- mem_addr  out  32  downstream address.
- mem_rmask  out  4  downstream read mask, nonzero for exactly one cycle per read.
- mem_wmask  out  4  downstream write mask, nonzero for exactly one cycle per write.
- mem_wdata  out  32  downstream write data.
- mem_rdata  in  32  downstream read data, valid with mem_resp.
- mem_resp  in  1  downstream completion pulse.

## Operation
- State machine: IDLE, BUSY_I, BUSY_D.
- Per-requester pending slot (valid bit + addr/masks/wdata) holds a request that could not be issued in its arrival cycle.
- Effective request per side = pending slot valid OR incoming mask nonzero this cycle.
- Issue point: in IDLE any cycle, or in BUSY_x the cycle mem_resp = 1. Winner chosen among effective requests, excluding the requester that currently owns the port. Ties resolved by DMEM_PRIO.
- Issue: at the edge, mem_* registers load the winner's fields, state → BUSY_winner, and the winner's pending slot clears. Loser's incoming request is captured into its pending slot.
- Downstream masks are zero in every cycle except the issue cycle. mem_addr and mem_wdata hold their last values.
- dmem with wmask != 0: write; mem_rmask forced 0 even if dmem_rmask is also nonzero. imem always issues as a read with its rmask.
- Completion (mem_resp = 1 in BUSY_x): at the edge, x_resp = 1 for one cycle and x_rdata ← mem_rdata. x_rdata holds until the next x completion. Then either issue the next request (back-to-back) or go to IDLE.
- mem_resp in IDLE is ignored.
- New request from a side whose transaction is pending or in flight (before its resp pulse) is a protocol violation: the request is ignored, and slot contents stay unchanged.
- No starvation: each side has at most one outstanding request, so the low-priority side waits at most one high-priority transaction.

## Timing
- Reset: state IDLE, both slots empty, all outputs 0 (mem_addr, mem_wdata, masks, rdata, resp).
- Reset mid-transaction drops pending and in-flight requests. Any later mem_resp is ignored (state IDLE).
- Issue latency from IDLE: request in cycle N → mem_* mask pulse in cycle N+1.
- Response latency: mem_resp in cycle M → requester resp/rdata in cycle M+1.
- Back-to-back: with the other side's request pending or arriving in cycle M, its mem_* pulse is in cycle M+1 (zero idle cycles).
- A requester sees resp in M+1 and may re-request at M+1 at the earliest. That request is issued no earlier than M+2.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then single imem read: imem_addr=0x1000, rmask=F in cycle 1 → mem_rmask=F, mem_addr=0x1000 in cycle 2. mem_resp with rdata=0xDEADBEEF in cycle 5 → imem_resp=1, imem_rdata=0xDEADBEEF in cycle 6; dmem_resp stays 0.
- Simultaneous requests, DMEM_PRIO=1: imem 0x2000 and dmem read 0x3004 rmask=3 in cycle 1 → dmem issued cycle 2. mem_resp in cycle 4 → dmem_resp cycle 5 and imem mem_rmask=F, addr 0x2000 in cycle 5.
- dmem write: addr 0x4000, wmask=4, wdata=0x00AB0000 → mem_wmask=4, mem_rmask=0, mem_wdata=0x00AB0000 one cycle later. mem_resp → dmem_resp; imem_rdata unchanged.
- Late arrival during busy: imem in flight, dmem request arrives cycle 3, mem_resp cycle 6 → dmem issued cycle 7 with slot data from cycle 3; dmem inputs changing after cycle 3 have no effect.
- Protocol violation: second imem request while imem in flight → ignored, exactly one mem_rmask pulse and one imem_resp.
- Reset mid-operation: rst in cycle 3 with dmem in flight and imem pending; mem_resp in cycle 5 → no resp pulses, no further mem masks, all outputs 0.
